// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the dual_port_ram storage block.
//   DATA_WIDTH : word width in bits (8)
//   ADDR_WIDTH : address width in bits (5)
//   DEPTH      : number of words, always 2**ADDR_WIDTH (32)
//   data_t     : one data word
//   addr_t     : one word address
package ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/ram_array.sv
// ram_array: storage array with asynchronous clear, synchronous write port and
// a combinational read of the addressed word.
// Ports:
//   clk     : clock, writes happen on its rising edge
//   rst     : asynchronous active-low clear of every word
//   wr_en   : write enable, active-high
//   addr    : word address (shared by read and write)
//   data_in : write data
//   rd_data : current content of mem[addr] (pre-write value during a write edge)
module ram_array #(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = ram_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array is reset because the block must read back zeros after any
  // reset; this forces flop-based storage rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every reader sees
  // the pre-edge value, which is what makes read-first work in the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr] <= data_in;
    end
  end

  assign rd_data = mem_q[addr];

endmodule : ram_array

// File: rtl/dual_port_ram.sv
// dual_port_ram: single-clock RAM with one shared address, independent write
// and read enables, synchronous write and registered synchronous read.
// Ports:
//   clk      : clock, all state changes on its rising edge except reset
//   rst      : asynchronous active-low reset, clears memory and data_out
//   data_in  : write data
//   wr_en    : write enable, active-high
//   rd_en    : read enable, active-high; data_out holds when low
//   addr     : word address shared by read and write
//   data_out : registered read data
// Configuration macro: RAM_WRITE_THROUGH_EN
//   defined   -> simultaneous read+write returns data_in (write-through)
//   undefined -> simultaneous read+write returns old mem[addr] (read-first)
module dual_port_ram #(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = ram_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] arr_rd_data;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] data_out_q;

  ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .addr   (addr),
    .data_in(data_in),
    .rd_data(arr_rd_data)
  );

  // NOTE: the next-state value defaults to the current one before any branch,
  // so this block never infers a latch when rd_en is low.
  always_comb begin
    data_out_d = data_out_q;
`ifdef RAM_WRITE_THROUGH_EN
    // Forward the incoming word when a write hits the address being read.
    if (rd_en) data_out_d = wr_en ? data_in : arr_rd_data;
`else
    // The array still shows its pre-write content at this edge: read-first.
    if (rd_en) data_out_d = arr_rd_data;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_out_q <= '0;
    else      data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed self-checking bench for dual_port_ram.
// Inputs change 1ns after a rising edge; outputs are sampled at that same
// point, well away from the next active edge.
module tb_dual_port_ram;

  localparam int DW = ram_pkg::DATA_WIDTH;
  localparam int AW = ram_pkg::ADDR_WIDTH;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  dual_port_ram dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; rd_en = 1'b0; addr = a; data_in = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a,
                         input logic [DW-1:0] exp);
    wr_en = 1'b0; rd_en = 1'b1; addr = a;
    step();
    rd_en = 1'b0;
    check(tag, data_out, exp);
  endtask

  initial begin
    logic [DW-1:0] exp_sim;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; data_in = '0;

    // Power-on reset
    step();
    check("por_data_out", data_out, 8'h00);
    step();
    rst = 1'b1;

    // Write then read, including the top address
    do_write(5'd3, 8'hA5);
    do_write(5'd31, 8'h3C);
    do_read("rd_addr3", 5'd3, 8'hA5);
    do_read("rd_addr31", 5'd31, 8'h3C);

    // Hold: rd_en low while the same word is overwritten
    do_read("hold_pre", 5'd3, 8'hA5);
    wr_en = 1'b1; rd_en = 1'b0; addr = 5'd3; data_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hold_c%0d", i), data_out, 8'hA5);
    end
    wr_en = 1'b0;
    do_read("hold_post", 5'd3, 8'hFF);

    // Simultaneous read and write to one address
    do_write(5'd5, 8'h11);
`ifdef RAM_WRITE_THROUGH_EN
    exp_sim = 8'h22;
`else
    exp_sim = 8'h11;
`endif
    wr_en = 1'b1; rd_en = 1'b1; addr = 5'd5; data_in = 8'h22;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("simul_rw", data_out, exp_sim);
    do_read("simul_after", 5'd5, 8'h22);

    // Full sweep: write addr*7, read all back-to-back with rd_en held high
    for (int a = 0; a < 32; a++) do_write(AW'(a), DW'(a * 7));
    rd_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      addr = AW'(a);
      step();
      check($sformatf("sweep_a%0d", a), data_out, DW'(a * 7));
    end
    rd_en = 1'b0;

    // Mid-simulation reset pulse, asserted between edges
    #2 rst = 1'b0;
    #1 check("rst_async_out", data_out, 8'h00);
    step();
    rst = 1'b1;
    do_read("rst_addr0", 5'd0, 8'h00);
    do_read("rst_addr17", 5'd17, 8'h00);
    do_read("rst_addr31", 5'd31, 8'h00);
    do_read("rst_addr5", 5'd5, 8'h00);

    // Reset across a write edge: the write is lost
    do_write(5'd8, 8'h5A);
    wr_en = 1'b1; addr = 5'd9; data_in = 8'h77;
    #3 rst = 1'b0;
    step();
    wr_en = 1'b0;
    check("rstw_out", data_out, 8'h00);
    rst = 1'b1;
    do_read("rstw_addr9", 5'd9, 8'h00);
    do_read("rstw_addr8", 5'd8, 8'h00);

    // First edge after release performs a write
    do_write(5'd9, 8'h42);
    do_read("post_rst_wr", 5'd9, 8'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_dual_port_ram

// File: doc/dual_port_ram.md
# dual_port_ram

Single-clock 32-word × 8-bit RAM used as the storage block under the RAM verification environment. It has one shared address, independent write and read enables, synchronous write and a registered synchronous read. It sits behind the `ram_interface` bundle, which drives all its inputs and samples `data_out`.

## Interface
- `DATA_WIDTH`, default 8: word width in bits.
- `ADDR_WIDTH`, default 5: address width in bits.
- `DEPTH`, default 32: number of words; must equal 2**`ADDR_WIDTH`.
- `clk`  input  1  single clock; all state changes on its rising edge, except reset.
- `rst`  input  1  reset, asynchronous, active-low.
- `data_in`  input  `DATA_WIDTH`  write data.
- `wr_en`  input  1  write enable, active-high.
- `rd_en`  input  1  read enable, active-high.
- `addr`  input  `ADDR_WIDTH`  word address, shared by read and write.
- `data_out`  output  `DATA_WIDTH`  registered read data.

## Operation
- Reset (`rst`=0):
  - Immediately clears all `DEPTH` words to 0, independent of `clk`.
  - Clears `data_out` to 0.
  - While `rst`=0, `wr_en` and `rd_en` are ignored and all state stays 0.
- Write: on a `clk` rising edge with `rst`=1 and `wr_en`=1, `mem[addr]` is loaded with `data_in`.
- Read: on a `clk` rising edge with `rst`=1 and `rd_en`=1, `data_out` is loaded with `mem[addr]`.
- `rd_en`=0: `data_out` holds its last value; it is never driven to X or Z.
- `wr_en`=0 and `rd_en`=0: no state change.
- `wr_en`=1 and `rd_en`=1 on the same edge: the write still occurs. The value returned is set by `RAM_WRITE_THROUGH_EN` (see Configuration).
- Address is always in range (`DEPTH`=2**`ADDR_WIDTH`), so there is no out-of-range case. Addresses 0 and 31 behave like any other address.
- No handshake and no busy state: every access completes on one edge. Back-to-back accesses on consecutive cycles are supported.

## Timing
- Write latency: `mem[addr]` is updated at edge N. A read of that address issued at edge N+1 returns the new data.
- Read latency: 1 cycle. `data_out` is valid after the edge that sampled `rd_en`=1 and stays valid until the next read edge or reset.
- Reset asserted mid-operation: takes effect immediately. An in-flight write on the same cycle is lost.
- Reset deassertion: the first edge with `rst`=1 can perform a read or a write.
- All inputs must be stable around the rising edge of `clk`. There are no combinational paths from inputs to `data_out`.

## Configuration
- `RAM_WRITE_THROUGH_EN` defined:
  - On a simultaneous read and write to `addr`, `data_out` gets `data_in` (new data, write-through).
- `RAM_WRITE_THROUGH_EN` undefined (default):
  - On a simultaneous read and write, `data_out` gets the pre-write content of `mem[addr]` (read-first).
  - The memory is updated with `data_in` in both modes.

## Structure
- Package `ram_pkg` holds:
  - the constants `DATA_WIDTH`=8, `ADDR_WIDTH`=5 and `DEPTH`=32;
  - the typedefs `data_t` (logic [`DATA_WIDTH`-1:0]) and `addr_t` (logic [`ADDR_WIDTH`-1:0]).
- Module parameters default from `ram_pkg`.
- One sub-module, `ram_array`:
  - contains the storage array, asynchronous clear and write port;
  - exposes a combinational read of `mem[addr]`.
- The top level owns:
  - the `data_out` register;
  - the write-through/read-first selection.

## Test plan
- Reset: pulse `rst`=0 mid-simulation, then read addresses 0, 17 and 31 -> `data_out`=0x00 each, one cycle after each read.
- Write then read: write 0xA5 to addr 3 and 0x3C to addr 31 -> read addr 3 returns 0xA5 and read addr 31 returns 0x3C, each one cycle after the read edge.
- Hold: read addr 3 (0xA5), then drive `rd_en`=0 for 4 cycles while writing 0xFF to addr 3 -> `data_out` stays 0xA5.
- Simultaneous access: addr 5 holds 0x11; assert `wr_en`=1 and `rd_en`=1 with `data_in`=0x22 -> `data_out`=0x11 by default, 0x22 with `RAM_WRITE_THROUGH_EN`; a following read returns 0x22 in both modes.
- Full sweep: write value addr×7 (mod 256) to all 32 addresses, then read all back-to-back -> every word matches, with no aliasing between addresses.
- Reset mid-write: assert `rst`=0 during a write of 0x77 to addr 9 -> after release, a read of addr 9 returns 0x00.
